hit_judge: RTL and testbench

Timing and pitch judge for play mode. Sits between the debounced hit capture stage and the scoreboard/high-score stage. It walks the song one note at a time: it presents `note_idx` to the song ROM and grades each player hit against the returned goal note. It then updates combo and score registers, which the downstream scoreboard displays and the per-user high-score table samples when `done` rises.

---
 rtl/hit_judge.sv | 198 +++++++++++++++++++
 tb/tb_hit_judge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// hit_judge: grades each player hit against the current song note and keeps
// combo/score totals. Inputs: en, hit_* pulse, sys_clock, track, goal_* from a
// combinational song ROM. Outputs: note_idx to the ROM, judge_valid/grade
// pulse, combo/max_combo/base_score/bonus_score, done.
module hit_judge #(
  parameter int CLOCK_W     = 24,
  parameter int CNT_W       = 8,
  parameter int PERFECT_WIN = 50,
  parameter int GOOD_WIN    = 150,
  parameter int MISS_WIN    = 300
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               hit_valid,
  input  logic [2:0]         hit_octave,
  input  logic [2:0]         hit_note,
  input  logic [2:0]         hit_length,
  input  logic [CLOCK_W-1:0] sys_clock,
  input  logic [CNT_W-1:0]   track,
  input  logic [CLOCK_W-1:0] goal_time,
  input  logic [2:0]         goal_octave,
  input  logic [2:0]         goal_note,
  input  logic [2:0]         goal_length,
  output logic [CNT_W-1:0]   note_idx,
  output logic               judge_valid,
  output logic [1:0]         grade,
  output logic [20:0]        combo,
  output logic [20:0]        max_combo,
  output logic [20:0]        base_score,
  output logic [20:0]        bonus_score,
  output logic               done
);

  localparam int OW = CLOCK_W + 1;
  localparam logic [OW-1:0] P_WIN = OW'(PERFECT_WIN);
  localparam logic [OW-1:0] G_WIN = OW'(GOOD_WIN);
  localparam logic [OW-1:0] M_WIN = OW'(MISS_WIN);
  localparam logic [20:0]   SAT   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_JUDGE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CLOCK_W-1:0] start_q, start_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         grade_q, grade_d;
  logic               len_q, len_d;
  logic [20:0]        combo_q, combo_d;
  logic [20:0]        max_q, max_d;
  logic [20:0]        base_q, base_d;
  logic [20:0]        bonus_q, bonus_d;

  logic [CLOCK_W-1:0] rel;
  logic [OW-1:0]      off;
  logic [OW-1:0]      mag;
  logic               in_win;
  logic               late;
  logic               pitch_ok;
  logic [1:0]         hit_grade;
  logic [CNT_W-1:0]   idx_inc;

  // off is a CLOCK_W+1 bit two's-complement value; its MSB is the sign.
  assign rel      = sys_clock - start_q;
  assign off      = {1'b0, rel} - {1'b0, goal_time};
  assign mag      = off[OW-1] ? (~off + 1'b1) : off;
  assign in_win   = (mag <= M_WIN);
  assign late     = !off[OW-1] && !in_win;
  assign pitch_ok = (hit_octave == goal_octave) &&
                    (hit_note == goal_note);
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    hit_grade = 2'd1;
    if (!pitch_ok)          hit_grade = 2'd0;
    else if (mag <= P_WIN)  hit_grade = 2'd3;
    else if (mag <= G_WIN)  hit_grade = 2'd2;
  end

  logic [8:0]  pts;
  logic [21:0] base_sum;
  logic [21:0] combo_inc;
  logic [22:0] bonus_sum;
  logic [20:0] base_new;
  logic [20:0] combo_new;
  logic [20:0] bonus_new;
  logic [20:0] max_new;
  logic        good;

  always_comb begin
    pts = 9'd0;
    unique case (grade_q)
      2'd3: pts = 9'd300;
      2'd2: pts = 9'd200;
      2'd1: pts = 9'd100;
      2'd0: pts = 9'd0;
    endcase
  end

  assign good      = grade_q[1];
  assign base_sum  = {1'b0, base_q} + 22'(pts);
  assign base_new  = base_sum[21] ? SAT : base_sum[20:0];
  assign combo_inc = {1'b0, combo_q} + 22'd1;
  assign combo_new = !good ? '0 :
                     combo_inc[21] ? SAT : combo_inc[20:0];
  assign max_new   = (combo_new > max_q) ? combo_new : max_q;
  // Length bonus only counts for a hit that was not a MISS.
  assign bonus_sum = {2'b0, bonus_q} + {2'b0, combo_new} +
                     ((len_q && grade_q != 2'd0) ? 23'd50 : 23'd0);
  assign bonus_new = (|bonus_sum[22:21]) ? SAT : bonus_sum[20:0];

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    idx_d   = idx_q;
    grade_d = grade_q;
    len_d   = len_q;
    combo_d = combo_q;
    max_d   = max_q;
    base_d  = base_q;
    bonus_d = bonus_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          start_d = sys_clock;
          idx_d   = '0;
          combo_d = '0;
          max_d   = '0;
          base_d  = '0;
          bonus_d = '0;
          state_d = (track == '0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          // A hit inside the window beats the timeout.
          if (hit_valid && in_win) begin
            grade_d = hit_grade;
            len_d   = (hit_length == goal_length);
            state_d = S_JUDGE;
          end else if (late) begin
            grade_d = 2'd0;
            len_d   = 1'b0;
            state_d = S_JUDGE;
          end
        end
        S_JUDGE: begin
          base_d  = base_new;
          combo_d = combo_new;
          max_d   = max_new;
          bonus_d = bonus_new;
          idx_d   = idx_inc;
          state_d = (idx_inc == track) ? S_DONE : S_WAIT;
        end
        S_DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= '0;
      idx_q   <= '0;
      grade_q <= '0;
      len_q   <= 1'b0;
      combo_q <= '0;
      max_q   <= '0;
      base_q  <= '0;
      bonus_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      grade_q <= grade_d;
      len_q   <= len_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      base_q  <= base_d;
      bonus_q <= bonus_d;
    end
  end

  assign note_idx    = idx_q;
  assign judge_valid = (state_q == S_JUDGE);
  assign grade       = grade_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign base_score  = base_q;
  assign bonus_score = bonus_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: randomized self-checking bench for hit_judge.
// Song ROM and score model live in the bench.
module tb_hit_judge;
  localparam int SAT = (1 << 21) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hit_valid = 1'b0;
  logic [2:0]  hit_octave = '0;
  logic [2:0]  hit_note = '0;
  logic [2:0]  hit_length = '0;
  logic [23:0] sys_clock = '0;
  logic [7:0]  track = '0;
  logic [23:0] goal_time;
  logic [2:0]  goal_octave, goal_note, goal_length;
  logic [7:0]  note_idx;
  logic        judge_valid, done;
  logic [1:0]  grade;
  logic [20:0] combo, max_combo, base_score, bonus_score;

  logic [23:0] song_t [256];
  logic [2:0]  song_o [256];
  logic [2:0]  song_n [256];
  logic [2:0]  song_l [256];

  assign goal_time   = song_t[note_idx];
  assign goal_octave = song_o[note_idx];
  assign goal_note   = song_n[note_idx];
  assign goal_length = song_l[note_idx];

  int tests = 0;
  int fails = 0;
  int e_base, e_combo, e_max, e_bonus, e_idx, e_track;
  int start_t;

  hit_judge dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hit_valid(hit_valid), .hit_octave(hit_octave),
    .hit_note(hit_note), .hit_length(hit_length),
    .sys_clock(sys_clock), .track(track),
    .goal_time(goal_time), .goal_octave(goal_octave),
    .goal_note(goal_note), .goal_length(goal_length),
    .note_idx(note_idx), .judge_valid(judge_valid),
    .grade(grade), .combo(combo), .max_combo(max_combo),
    .base_score(base_score), .bonus_score(bonus_score),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int ref_grade(int off, bit pok);
    int a;
    a = (off < 0) ? -off : off;
    if (!pok) return 0;
    if (a <= 50) return 3;
    if (a <= 150) return 2;
    return 1;
  endfunction

  function automatic int clampi(int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_apply(int g, bit lok);
    e_base = clampi(e_base + 100 * g);
    e_combo = (g >= 2) ? clampi(e_combo + 1) : 0;
    if (e_combo > e_max) e_max = e_combo;
    e_bonus = clampi(e_bonus + ((g >= 2) ? e_combo : 0) +
                     ((lok && g != 0) ? 50 : 0));
    e_idx++;
  endtask

  task automatic make_song(int n);
    for (int i = 0; i < n; i++) begin
      song_t[i] = 24'($urandom_range(3000, 1 << 22));
      song_o[i] = 3'($urandom_range(0, 7));
      song_n[i] = 3'($urandom_range(0, 7));
      song_l[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic start_song(int n, int st);
    en = 1'b0;
    hit_valid = 1'b0;
    @(negedge clk);
    track = 8'(n);
    start_t = st & 24'hFFFFFF;
    sys_clock = 24'(start_t);
    en = 1'b1;
    @(negedge clk);
    e_base = 0; e_combo = 0; e_max = 0; e_bonus = 0;
    e_idx = 0; e_track = n;
    tests++;
    if ({note_idx, combo, max_combo, base_score, bonus_score} !== '0 ||
        done !== (n == 0)) begin
      fails++;
      $display("FAIL start: idx=%0d base=%0d bonus=%0d done=%b, required 0/0/0/%b",
               note_idx, base_score, bonus_score, done, n == 0);
    end
  endtask

  task automatic judge_note(int off, bit hit, bit pok, bit lok, bit hij);
    int g, gi;
    gi = e_idx;
    sys_clock = 24'(start_t + int'(song_t[gi]) + off);
    hit_valid = hit;
    hit_octave = pok ? song_o[gi] : song_o[gi] ^ 3'd1;
    hit_note = song_n[gi];
    hit_length = lok ? song_l[gi] : song_l[gi] ^ 3'd2;
    if (hit && off >= -300 && off <= 300) g = ref_grade(off, pok);
    else g = 0;
    @(negedge clk);
    hit_valid = hij;
    tests++;
    if (judge_valid !== 1'b1 || grade !== 2'(g) || done !== 1'b0) begin
      fails++;
      $display("FAIL judge_pulse off=%0d: valid=%b grade=%0d done=%b, required 1/%0d/0",
               off, judge_valid, grade, done, g);
    end
    model_apply(g, hit && lok);
    @(negedge clk);
    hit_valid = 1'b0;
    tests++;
    if (judge_valid !== 1'b0 || note_idx !== 8'(e_idx) ||
        combo !== 21'(e_combo) || max_combo !== 21'(e_max) ||
        base_score !== 21'(e_base) || bonus_score !== 21'(e_bonus) ||
        done !== (e_idx == e_track)) begin
      fails++;
      $display("FAIL judge_result: v=%b idx=%0d combo=%0d max=%0d base=%0d bonus=%0d done=%b, required 0/%0d/%0d/%0d/%0d/%0d/%b",
               judge_valid, note_idx, combo, max_combo, base_score,
               bonus_score, done, e_idx, e_combo, e_max, e_base,
               e_bonus, e_idx == e_track);
    end
  endtask

  task automatic early_hit(int off);
    sys_clock = 24'(start_t + int'(song_t[e_idx]) + off);
    hit_valid = 1'b1;
    hit_octave = song_o[e_idx];
    hit_note = song_n[e_idx];
    @(negedge clk);
    hit_valid = 1'b0;
    tests++;
    if (judge_valid !== 1'b0) begin
      fails++;
      $display("FAIL early_hit off=%0d: valid=%b, required 0", off, judge_valid);
    end
    @(negedge clk);
    tests++;
    if (judge_valid !== 1'b0 || note_idx !== 8'(e_idx)) begin
      fails++;
      $display("FAIL early_hold: valid=%b idx=%0d, required 0/%0d",
               judge_valid, note_idx, e_idx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({note_idx, judge_valid, grade, combo, max_combo, base_score,
         bonus_score, done} !== '0) begin
      fails++;
      $display("FAIL reset: idx=%0d v=%b g=%0d base=%0d done=%b, required all 0",
               note_idx, judge_valid, grade, base_score, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    song_t[0] = 24'd1000;
    song_o[0] = 3'd4;
    song_n[0] = 3'd0;
    song_l[0] = 3'd2;
    start_song(1, int'($urandom_range(0, 24'hFFFFFF)));
    judge_note(20, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_track0;
    start_song(0, 12345);
  endtask

  task automatic test_grades;
    make_song(12);
    start_song(12, int'($urandom_range(0, 24'hFFFFFF)));
    judge_note(100, 1, 1, 1, 0);
    judge_note(-200, 1, 1, 0, 0);
    judge_note(301 + int'($urandom_range(0, 500)), 0, 1, 1, 0);
    early_hit(-400);
    judge_note(0, 1, 1, 1, 0);
    judge_note(0, 1, 0, 1, 1);
    judge_note(50, 1, 1, 1, 0);
    judge_note(51, 1, 1, 0, 0);
    judge_note(-150, 1, 1, 1, 0);
    judge_note(-151, 1, 1, 1, 0);
    judge_note(300, 1, 1, 1, 0);
    judge_note(-300, 1, 1, 1, 0);
    early_hit(-301);
    judge_note(301, 1, 1, 1, 0);
  endtask

  task automatic test_random;
    for (int s = 0; s < 3; s++) begin
      int n;
      n = int'($urandom_range(10, 40));
      make_song(n);
      start_song(n, int'($urandom_range(0, 24'hFFFFFF)));
      for (int k = 0; k < n; k++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) early_hit(-int'($urandom_range(301, 2000)));
        if (r == 1)
          judge_note(int'($urandom_range(301, 2000)), 1'b0, 1'b1,
                     1'b1, 1'b0);
        else
          judge_note(int'($urandom_range(0, 600)) - 300, 1'b1,
                     ($urandom_range(0, 4) != 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_en_drop;
    make_song(6);
    start_song(6, int'($urandom_range(0, 24'hFFFFFF)));
    for (int k = 0; k < 3; k++)
      judge_note(int'($urandom_range(0, 200)) - 100, 1, 1, 1, 0);
    en = 1'b0;
    @(negedge clk);
    sys_clock = 24'($urandom);
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (judge_valid !== 1'b0 || done !== 1'b0 || note_idx !== 8'(e_idx) ||
        combo !== 21'(e_combo) || base_score !== 21'(e_base) ||
        bonus_score !== 21'(e_bonus) || max_combo !== 21'(e_max)) begin
      fails++;
      $display("FAIL en_hold: idx=%0d combo=%0d base=%0d bonus=%0d, required %0d/%0d/%0d/%0d",
               note_idx, combo, base_score, bonus_score, e_idx, e_combo,
               e_base, e_bonus);
    end
    start_song(6, int'($urandom_range(0, 24'hFFFFFF)));
    judge_note(0, 1, 1, 1, 0);
  endtask

  task automatic test_async;
    make_song(4);
    start_song(4, int'($urandom_range(0, 24'hFFFFFF)));
    judge_note(10, 1, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({note_idx, judge_valid, grade, combo, max_combo, base_score,
         bonus_score, done} !== '0) begin
      fails++;
      $display("FAIL async_reset: idx=%0d g=%0d base=%0d bonus=%0d, required all 0",
               note_idx, grade, base_score, bonus_score);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      song_t[i] = 24'd3000;
      song_o[i] = '0;
      song_n[i] = '0;
      song_l[i] = '0;
    end
    test_reset();
    test_single();
    test_track0();
    test_grades();
    test_random();
    test_en_drop();
    test_async();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
